// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory bus arbiter.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_DREAD = 3'd2,
        ST_IREAD = 3'd3,
        ST_RESP  = 3'd4
    } arb_state_e;

    // Instruction returned when an instruction refill is abandoned (addi x0,x0,0)
    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    // Bus opcode on o_mem_we
    localparam logic BUS_OP_RD = 1'b0;
    localparam logic BUS_OP_WR = 1'b1;

    // One buffered store
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wb_entry_t;

endpackage

// File: rtl/mem_arb_wbuf.sv
// Store FIFO holding write-through stores until the bus accepts them.
// DEPTH must be a power of two, minimum 2.
module mem_arb_wbuf
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  wb_entry_t                  push_entry_i,
    input  logic                       pop_i,
    output wb_entry_t                  head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t         mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PW:0]       count_q, count_d;

    // Storage needs no reset; only the pointers define what is valid
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_entry_i;
    end

    // Occupancy: simultaneous push and pop leaves it unchanged
    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Merges icache refills, dcache refills and buffered stores onto one
// valid/ack memory bus. Stores drain before any read (store->load order).
// Optional feature: MEM_ARB_TIMEOUT_EN adds an ack watchdog that aborts a
// stuck transfer and raises the sticky o_bus_err flag.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WB_DEPTH       = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_iread_en,
    input  logic [31:0] i_iaddr,
    output logic        o_iread_vd,
    output logic [31:0] o_inst,
    input  logic        i_read_en,
    input  logic        i_write_en,
    input  logic [31:0] i_memaddr,
    input  logic [31:0] i_write_data,
    output logic        o_read_vd,
    output logic [31:0] o_read_data,
    output logic        o_exstall,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_bus_err
);

    arb_state_e  state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] inst_q, inst_d;
    logic        rvd_q, rvd_d;
    logic        ivd_q, ivd_d;

    logic        wb_push, wb_pop, wb_full, wb_empty;
    wb_entry_t   wb_head, wb_in;
    logic [$clog2(WB_DEPTH):0] wb_count_unused;

    logic        xfer_done;
    logic        tmo_abort;

    assign wb_in   = '{addr: i_memaddr, data: i_write_data};
    assign wb_push = i_write_en && !wb_full;

    mem_arb_wbuf #(.DEPTH(WB_DEPTH)) u_wbuf (
        .clk          (clk),
        .rst          (rst),
        .push_i       (wb_push),
        .push_entry_i (wb_in),
        .pop_i        (wb_pop),
        .head_o       (wb_head),
        .full_o       (wb_full),
        .empty_o      (wb_empty),
        .count_o      (wb_count_unused)
    );

    assign xfer_done = req_q && i_mem_ack;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [TW-1:0] tmo_q;
    logic          err_q;

    // Abort on the last allowed request cycle so the result appears exactly
    // TIMEOUT_CYCLES cycles after o_mem_req rose
    assign tmo_abort = req_q && !i_mem_ack && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    // Watchdog counts request-high cycles; error flag is sticky
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= (req_q && !xfer_done && !tmo_abort) ? tmo_q + 1'b1 : '0;
            if (tmo_abort) err_q <= 1'b1;
        end
    end

    assign o_bus_err = err_q;
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign tmo_abort  = 1'b0;
    assign o_bus_err  = 1'b0;
`endif

    // Arbitration and transfer sequencing; bus outputs are registered
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        inst_d  = inst_q;
        rvd_d   = 1'b0;
        ivd_d   = 1'b0;
        wb_pop  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!wb_empty) begin
                    wb_pop  = 1'b1;
                    state_d = ST_WRITE;
                    req_d   = 1'b1;
                    we_d    = BUS_OP_WR;
                    addr_d  = wb_head.addr;
                    wdata_d = wb_head.data;
                end else if (i_read_en) begin
                    state_d = ST_DREAD;
                    req_d   = 1'b1;
                    we_d    = BUS_OP_RD;
                    addr_d  = i_memaddr;
                end else if (i_iread_en) begin
                    state_d = ST_IREAD;
                    req_d   = 1'b1;
                    we_d    = BUS_OP_RD;
                    addr_d  = i_iaddr;
                end
            end
            ST_WRITE: begin
                // An aborted store is simply dropped
                if (xfer_done || tmo_abort) begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_DREAD: begin
                if (xfer_done || tmo_abort) begin
                    req_d   = 1'b0;
                    rdata_d = xfer_done ? i_mem_rdata : 32'h0;
                    rvd_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_IREAD: begin
                if (xfer_done || tmo_abort) begin
                    req_d   = 1'b0;
                    inst_d  = xfer_done ? i_mem_rdata : RV_NOP;
                    ivd_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            // One dead cycle lets the cache drop its level request
            ST_RESP: state_d = ST_IDLE;
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            inst_q  <= '0;
            rvd_q   <= 1'b0;
            ivd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            inst_q  <= inst_d;
            rvd_q   <= rvd_d;
            ivd_q   <= ivd_d;
        end
    end

    assign o_mem_req   = req_q;
    assign o_mem_we    = we_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_read_data = rdata_q;
    assign o_inst      = inst_q;
    assign o_read_vd   = rvd_q;
    assign o_iread_vd  = ivd_q;
    assign o_exstall   = wb_full;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter. Inputs change 1 ns after the rising
// edge and outputs are sampled at that point too.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_iread_en, i_read_en, i_write_en, i_mem_ack;
    logic [31:0] i_iaddr, i_memaddr, i_write_data, i_mem_rdata;
    logic        o_iread_vd, o_read_vd, o_exstall, o_mem_req, o_mem_we, o_bus_err;
    logic [31:0] o_inst, o_read_data, o_mem_addr, o_mem_wdata;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.WB_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_iread_en  (i_iread_en),
        .i_iaddr     (i_iaddr),
        .o_iread_vd  (o_iread_vd),
        .o_inst      (o_inst),
        .i_read_en   (i_read_en),
        .i_write_en  (i_write_en),
        .i_memaddr   (i_memaddr),
        .i_write_data(i_write_data),
        .o_read_vd   (o_read_vd),
        .o_read_data (o_read_data),
        .o_exstall   (o_exstall),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_ack   (i_mem_ack),
        .i_mem_rdata (i_mem_rdata),
        .o_bus_err   (o_bus_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] st_addr [6];
    logic [31:0] st_data [6];
    logic [31:0] wr_addr [6];
    logic [31:0] wr_data [6];
    int          idx, nwr;

    initial begin
        rst = 1'b0;
        i_iread_en = 0; i_read_en = 0; i_write_en = 0; i_mem_ack = 0;
        i_iaddr = 0; i_memaddr = 0; i_write_data = 0; i_mem_rdata = 0;
        #12;
        check("rst_req",    32'(o_mem_req),  0);
        check("rst_we",     32'(o_mem_we),   0);
        check("rst_addr",   o_mem_addr,      0);
        check("rst_ivd",    32'(o_iread_vd), 0);
        check("rst_rvd",    32'(o_read_vd),  0);
        check("rst_stall",  32'(o_exstall),  0);
        check("rst_err",    32'(o_bus_err),  0);
        check("rst_inst",   o_inst,          0);
        step();
        rst = 1'b1;

        // ---- instruction fetch only ----
        i_iread_en = 1; i_iaddr = 32'h100;
        check("if_c0_req", 32'(o_mem_req), 0);
        step();
        check("if_c1_req",  32'(o_mem_req), 1);
        check("if_c1_addr", o_mem_addr, 32'h100);
        check("if_c1_we",   32'(o_mem_we), 0);
        step();
        check("if_c2_req", 32'(o_mem_req), 1);
        step();
        i_mem_ack = 1; i_mem_rdata = 32'h0050_0093;
        check("if_c3_ivd", 32'(o_iread_vd), 0);
        step();
        i_mem_ack = 0;
        check("if_c4_ivd",  32'(o_iread_vd), 1);
        check("if_c4_inst", o_inst, 32'h0050_0093);
        check("if_c4_req",  32'(o_mem_req), 0);
        step();
        i_iread_en = 0;
        check("if_c5_ivd",   32'(o_iread_vd), 0);
        check("if_c5_noreq", 32'(o_mem_req), 0);
        step();
        check("if_c6_noreq", 32'(o_mem_req), 0);
        check("if_c6_inst",  o_inst, 32'h0050_0093);

        // ---- store then load to the same address ----
        i_write_en = 1; i_memaddr = 32'h40; i_write_data = 32'hDEAD;
        step();
        i_write_en = 0; i_read_en = 1;
        check("sl_c1_req", 32'(o_mem_req), 0);
        step();
        check("sl_c2_req",   32'(o_mem_req), 1);
        check("sl_c2_we",    32'(o_mem_we), 1);
        check("sl_c2_addr",  o_mem_addr, 32'h40);
        check("sl_c2_wdata", o_mem_wdata, 32'hDEAD);
        i_mem_ack = 1;
        step();
        i_mem_ack = 0;
        check("sl_c3_req", 32'(o_mem_req), 0);
        step();
        check("sl_c4_req",  32'(o_mem_req), 1);
        check("sl_c4_we",   32'(o_mem_we), 0);
        check("sl_c4_addr", o_mem_addr, 32'h40);
        i_mem_ack = 1; i_mem_rdata = 32'hDEAD;
        step();
        i_mem_ack = 0; i_read_en = 0;
        check("sl_c5_rvd",  32'(o_read_vd), 1);
        check("sl_c5_data", o_read_data, 32'hDEAD);
        step();
        check("sl_c6_rvd",  32'(o_read_vd), 0);
        check("sl_c6_hold", o_read_data, 32'hDEAD);

        // ---- fill the store buffer with ack withheld, then drain ----
        for (int k = 0; k < 6; k++) begin
            st_addr[k] = 32'h1000 + 32'(k * 4);
            st_data[k] = 32'hA000 + 32'(k);
        end
        idx = 0; nwr = 0;
        for (int c = 0; c < 40; c++) begin
            i_mem_ack = (c >= 6);
            if (idx < 6) begin
                i_write_en = 1; i_memaddr = st_addr[idx]; i_write_data = st_data[idx];
            end else begin
                i_write_en = 0;
            end
            if (c == 4) check("fill_c4_stall", 32'(o_exstall), 0);
            if (c == 5) check("fill_c5_stall", 32'(o_exstall), 1);
            if (c == 5) check("fill_c5_addr",  o_mem_addr, st_addr[0]);
            if (c == 7) check("fill_c7_stall", 32'(o_exstall), 1);
            if (c == 8) check("fill_c8_stall", 32'(o_exstall), 0);
            if (o_mem_req && i_mem_ack && o_mem_we && nwr < 6) begin
                wr_addr[nwr] = o_mem_addr;
                wr_data[nwr] = o_mem_wdata;
                nwr++;
            end
            if (i_write_en && !o_exstall) idx++;
            step();
        end
        i_write_en = 0; i_mem_ack = 0;
        check("fill_pushes", 32'(idx), 6);
        check("fill_writes", 32'(nwr), 6);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("fill_wa%0d", k), wr_addr[k], st_addr[k]);
            check($sformatf("fill_wd%0d", k), wr_data[k], st_data[k]);
        end
        check("fill_end_stall", 32'(o_exstall), 0);
        step();
        check("fill_end_req", 32'(o_mem_req), 0);

        // ---- simultaneous data and instruction refill ----
        i_read_en = 1; i_memaddr = 32'h80; i_iread_en = 1; i_iaddr = 32'h200;
        step();
        check("pr_c1_req",  32'(o_mem_req), 1);
        check("pr_c1_addr", o_mem_addr, 32'h80);
        i_mem_ack = 1; i_mem_rdata = 32'h1111;
        step();
        i_mem_ack = 0; i_read_en = 0;
        check("pr_c2_rvd",  32'(o_read_vd), 1);
        check("pr_c2_ivd",  32'(o_iread_vd), 0);
        check("pr_c2_data", o_read_data, 32'h1111);
        step();
        check("pr_c3_req", 32'(o_mem_req), 0);
        step();
        check("pr_c4_req",  32'(o_mem_req), 1);
        check("pr_c4_addr", o_mem_addr, 32'h200);
        i_mem_ack = 1; i_mem_rdata = 32'h2222;
        step();
        i_mem_ack = 0; i_iread_en = 0;
        check("pr_c5_ivd",  32'(o_iread_vd), 1);
        check("pr_c5_inst", o_inst, 32'h2222);
        check("pr_c5_dhold", o_read_data, 32'h1111);
        step();

        // ---- reset in the middle of a data read ----
        i_read_en = 1; i_memaddr = 32'h300;
        step();
        check("rs_c1_req", 32'(o_mem_req), 1);
        #2 rst = 1'b0;
        #1;
        check("rs_req",   32'(o_mem_req), 0);
        check("rs_addr",  o_mem_addr, 0);
        check("rs_rdata", o_read_data, 0);
        check("rs_inst",  o_inst, 0);
        check("rs_stall", 32'(o_exstall), 0);
        i_read_en = 0;
        #1 rst = 1'b1;
        i_mem_ack = 1; i_mem_rdata = 32'h5555;
        step();
        check("rs_late_rvd", 32'(o_read_vd), 0);
        check("rs_late_req", 32'(o_mem_req), 0);
        step();
        check("rs_late_rvd2", 32'(o_read_vd), 0);
        check("rs_late_data", o_read_data, 0);
        i_mem_ack = 0;
        step();

`ifdef MEM_ARB_TIMEOUT_EN
        // ---- instruction fetch that is never acked ----
        i_iread_en = 1; i_iaddr = 32'h400;
        for (int c = 1; c <= 9; c++) begin
            step();
            if (c == 1) check("to_c1_req", 32'(o_mem_req), 1);
            if (c == 8) check("to_c8_ivd", 32'(o_iread_vd), 0);
        end
        i_iread_en = 0;
        check("to_c9_ivd",  32'(o_iread_vd), 1);
        check("to_c9_inst", o_inst, 32'h0000_0013);
        check("to_c9_err",  32'(o_bus_err), 1);
        step();
        step();
        check("to_err_sticky", 32'(o_bus_err), 1);
`else
        check("no_bus_err", 32'(o_bus_err), 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
